pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PROG0_BASE, default 16'h0000, start address of program 0.
REQ-002 Parameter PROG1_BASE, default 16'h0100, start address of program 1.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  synchronous restart request.
REQ-006 prog_sel  input  1  selects the start address used on start: 0 = PROG0_BASE, 1 = PROG1_BASE.
REQ-007 halt  input  1  current instruction is a halt.
REQ-008 branch_taken  input  1  current instruction redirects the PC; already qualified by the ALU zero flag.
REQ-009 branch_abs  input  1  1 = absolute target, 0 = relative target.
REQ-010 branch_offset  input  6  two's-complement relative offset, taken from instruction bits 5:0.
REQ-011 branch_target  input  16  absolute target, taken from the register file.
REQ-012 PC  output  16  instruction address driven to both instruction ROMs.
REQ-013 running  output  1  high in state RUN.
REQ-014 halted  output  1  high in state HALTED.
REQ-015 pc_wrap  output  1  sticky flag: the PC has wrapped past 16'hFFFF.
REQ-016 inst_count  output  16  number of retired instructions (present only under the Configuration macro).

Function
REQ-017 The block SHALL have exactly three states: IDLE, RUN and HALTED.
REQ-018 start=1 in any state SHALL, on the next edge:
- load PC with the base selected by prog_sel;
- clear inst_count and pc_wrap;
- enter RUN.
REQ-019 start SHALL take priority over halt and branch_taken in the same cycle.
REQ-020 In IDLE and HALTED without start, PC, inst_count and pc_wrap SHALL hold, and halt and branch inputs SHALL be ignored.
REQ-021 In RUN with halt=1, the block SHALL enter HALTED on the next edge.
- PC SHALL hold the address of the halt instruction.
- inst_count SHALL increment once, so the halt instruction is counted.
- halt SHALL take priority over branch_taken.
REQ-022 In RUN with halt=0 and branch_taken=1, branch_abs=1: the next PC SHALL be branch_target.
REQ-023 In RUN with halt=0 and branch_taken=1, branch_abs=0: the next PC SHALL be PC + 1 + sign_extend(branch_offset), modulo 2^16.
REQ-024 In RUN with halt=0 and branch_taken=0: the next PC SHALL be PC + 1, modulo 2^16.
REQ-025 Redirect latency SHALL be one cycle; there are no delay slots and no stalls.
REQ-026 pc_wrap SHALL set when a sequential increment in RUN takes PC from 16'hFFFF to 16'h0000.
- It SHALL stay set until start or reset.
- Branches that cross 16'hFFFF/16'h0000 SHALL NOT set it.
REQ-027 inst_count SHALL increment by 1 per RUN cycle and saturate at 16'hFFFF.
REQ-028 running and halted SHALL be registered and never high together.

Reset
REQ-029 RST_N=0 SHALL immediately, independent of CLK, force:
- state = IDLE;
- PC = PROG0_BASE;
- running = 0, halted = 0, pc_wrap = 0, inst_count = 0.
REQ-030 Reset asserted mid-RUN SHALL abandon any pending branch.
REQ-031 After RST_N deasserts, the block SHALL remain in IDLE until start=1.

Configuration
REQ-032 Macro PC_SEQUENCER_INST_COUNT_EN.
- Defined: the inst_count port and its counter SHALL exist as specified in REQ-016 and REQ-027.
- Undefined: the port and its counter SHALL be absent.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-033 Reset, then start=1 with prog_sel=1 for one cycle, then run free -> PC sequence 0x0100, 0x0101, 0x0102; running=1.
REQ-034 At PC=0x0010, branch_taken=1, branch_abs=0, offset=6'b111100 -> next PC=0x000D; at PC=0x000D, branch_abs=1, target=0x1234 -> next PC=0x1234.
REQ-035 halt=1 and branch_taken=1 together at PC=0x0020 -> PC holds 0x0020, halted=1, running=0; inst_count (macro defined) equals retired instructions including the halt.
REQ-036 Start at PC 0xFFFE via an absolute branch, then run sequentially -> PC sequence 0xFFFF, 0x0000; pc_wrap=1 from the 0x0000 cycle; a subsequent start clears it.
REQ-037 Assert RST_N=0 between clock edges during RUN with branch_taken=1 -> PC=0x0000 and state IDLE immediately; after release, PC holds with no start.
REQ-038 start=1 and halt=1 in the same cycle while HALTED -> RUN entered, PC=selected base, inst_count=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer: start/run/halt control with relative and absolute branches.
// Latency: one cycle from start, halt or branch inputs to the new PC and state.
// No backpressure; the PC advances every RUN cycle. Optional counter: PC_SEQUENCER_INST_COUNT_EN.
module pc_sequencer #(
    parameter logic [15:0] PROG0_BASE = 16'h0000,
    parameter logic [15:0] PROG1_BASE = 16'h0100
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic        prog_sel,
    input  logic        halt,
    input  logic        branch_taken,
    input  logic        branch_abs,
    input  logic [5:0]  branch_offset,
    input  logic [15:0] branch_target,
    output logic [15:0] PC,
    output logic        running,
    output logic        halted,
`ifdef PC_SEQUENCER_INST_COUNT_EN
    output logic [15:0] inst_count,
`endif
    output logic        pc_wrap
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] pc_seq;
    logic [15:0] pc_rel;
    logic [15:0] start_base;

    // Candidate next-PC values; relative targets are taken from the sequential address.
    always_comb begin
        pc_seq     = PC + 16'd1;
        pc_rel     = pc_seq + {{10{branch_offset[5]}}, branch_offset};
        start_base = prog_sel ? PROG1_BASE : PROG0_BASE;
    end

    // Control FSM with registered status outputs; start overrides halt and branch.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            PC         <= PROG0_BASE;
            running    <= 1'b0;
            halted     <= 1'b0;
            pc_wrap    <= 1'b0;
`ifdef PC_SEQUENCER_INST_COUNT_EN
            inst_count <= 16'h0000;
`endif
        end else if (start) begin
            state      <= RUN;
            PC         <= start_base;
            running    <= 1'b1;
            halted     <= 1'b0;
            pc_wrap    <= 1'b0;
`ifdef PC_SEQUENCER_INST_COUNT_EN
            inst_count <= 16'h0000;
`endif
        end else begin
            case (state)
                RUN: begin
`ifdef PC_SEQUENCER_INST_COUNT_EN
                    // Every RUN cycle retires one instruction, the halt included.
                    if (inst_count != 16'hFFFF) begin
                        inst_count <= inst_count + 16'd1;
                    end
`endif
                    if (halt) begin
                        // PC stays on the halt instruction.
                        state   <= HALTED;
                        running <= 1'b0;
                        halted  <= 1'b1;
                    end else if (branch_taken) begin
                        // Branches never touch the wrap flag, even when crossing zero.
                        PC <= branch_abs ? branch_target : pc_rel;
                    end else begin
                        PC <= pc_seq;
                        if (PC == 16'hFFFF) begin
                            pc_wrap <= 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and HALTED hold everything until start.
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// The instruction counter is checked only when PC_SEQUENCER_INST_COUNT_EN is defined.
module tb_pc_sequencer;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic        prog_sel;
    logic        halt;
    logic        branch_taken;
    logic        branch_abs;
    logic [5:0]  branch_offset;
    logic [15:0] branch_target;
    logic [15:0] PC;
    logic        running;
    logic        halted;
    logic        pc_wrap;
`ifdef PC_SEQUENCER_INST_COUNT_EN
    logic [15:0] inst_count;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    pc_sequencer dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .start         (start),
        .prog_sel      (prog_sel),
        .halt          (halt),
        .branch_taken  (branch_taken),
        .branch_abs    (branch_abs),
        .branch_offset (branch_offset),
        .branch_target (branch_target),
        .PC            (PC),
        .running       (running),
        .halted        (halted),
`ifdef PC_SEQUENCER_INST_COUNT_EN
        .inst_count    (inst_count),
`endif
        .pc_wrap       (pc_wrap)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [15:0] pc_exp,
                               input logic run_exp, input logic halt_exp, input logic wrap_exp);
        check_eq({tag, "_pc"}, {16'h0, PC}, {16'h0, pc_exp});
        check_eq({tag, "_running"}, {31'h0, running}, {31'h0, run_exp});
        check_eq({tag, "_halted"}, {31'h0, halted}, {31'h0, halt_exp});
        check_eq({tag, "_wrap"}, {31'h0, pc_wrap}, {31'h0, wrap_exp});
    endtask

    task automatic check_count(input string tag, input logic [15:0] exp);
`ifdef PC_SEQUENCER_INST_COUNT_EN
        check_eq({tag, "_count"}, {16'h0, inst_count}, {16'h0, exp});
`else
        if (exp == 16'hFFFF) $display("note: counter build disabled (%s)", tag);
`endif
    endtask

    initial begin
        RST_N         = 1'b0;
        start         = 1'b0;
        prog_sel      = 1'b0;
        halt          = 1'b0;
        branch_taken  = 1'b0;
        branch_abs    = 1'b0;
        branch_offset = 6'd0;
        branch_target = 16'h0000;

        // Reset state
        repeat (2) step();
        check_state("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        check_count("reset", 16'h0000);

        // Stays idle after release, branch/halt ignored
        RST_N        = 1'b1;
        branch_taken = 1'b1;
        branch_abs   = 1'b1;
        branch_target = 16'h4444;
        halt         = 1'b1;
        repeat (2) step();
        check_state("idle_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
        branch_taken = 1'b0;
        branch_abs   = 1'b0;
        halt         = 1'b0;

        // Start program 1 and run free
        start    = 1'b1;
        prog_sel = 1'b1;
        step();
        start    = 1'b0;
        prog_sel = 1'b0;
        check_state("start1", 16'h0100, 1'b1, 1'b0, 1'b0);
        check_count("start1", 16'h0000);
        step();
        check_eq("seq_0101", {16'h0, PC}, 32'h0101);
        step();
        check_eq("seq_0102", {16'h0, PC}, 32'h0102);
        check_count("seq_0102", 16'h0002);

        // Absolute to 0x0010, relative -4 to 0x000D, absolute to 0x1234, relative +5
        branch_taken  = 1'b1;
        branch_abs    = 1'b1;
        branch_target = 16'h0010;
        step();
        check_eq("abs_0010", {16'h0, PC}, 32'h0010);
        branch_abs    = 1'b0;
        branch_offset = 6'b111100;
        step();
        check_eq("rel_neg", {16'h0, PC}, 32'h000D);
        branch_abs    = 1'b1;
        branch_target = 16'h1234;
        step();
        check_eq("abs_1234", {16'h0, PC}, 32'h1234);
        branch_abs    = 1'b0;
        branch_offset = 6'b000101;
        step();
        check_eq("rel_pos", {16'h0, PC}, 32'h123A);
        branch_abs    = 1'b1;
        branch_target = 16'h0020;
        step();
        check_eq("abs_0020", {16'h0, PC}, 32'h0020);

        // Halt wins over branch; 8 instructions retired including the halt
        halt          = 1'b1;
        branch_target = 16'h7777;
        step();
        check_state("halt", 16'h0020, 1'b0, 1'b1, 1'b0);
        check_count("halt", 16'h0008);
        repeat (2) step();
        check_state("halted_hold", 16'h0020, 1'b0, 1'b1, 1'b0);
        check_count("halted_hold", 16'h0008);

        // start + halt while HALTED: start wins, program 0
        start    = 1'b1;
        prog_sel = 1'b0;
        step();
        start        = 1'b0;
        halt         = 1'b0;
        check_state("restart", 16'h0000, 1'b1, 1'b0, 1'b0);
        check_count("restart", 16'h0000);

        // Branch crossing 0xFFFF->0x0002 must not set wrap
        branch_abs    = 1'b1;
        branch_target = 16'hFFFF;
        step();
        check_eq("abs_ffff", {16'h0, PC}, 32'hFFFF);
        branch_abs    = 1'b0;
        branch_offset = 6'b000010;
        step();
        check_state("rel_cross", 16'h0002, 1'b1, 1'b0, 1'b0);

        // Sequential wrap sets the sticky flag
        branch_abs    = 1'b1;
        branch_target = 16'hFFFE;
        step();
        branch_taken  = 1'b0;
        check_state("wrap_fffe", 16'hFFFE, 1'b1, 1'b0, 1'b0);
        step();
        check_state("wrap_ffff", 16'hFFFF, 1'b1, 1'b0, 1'b0);
        step();
        check_state("wrap_0000", 16'h0000, 1'b1, 1'b0, 1'b1);
        step();
        check_state("wrap_sticky", 16'h0001, 1'b1, 1'b0, 1'b1);
        start    = 1'b1;
        prog_sel = 1'b1;
        step();
        start    = 1'b0;
        prog_sel = 1'b0;
        check_state("wrap_clear", 16'h0100, 1'b1, 1'b0, 1'b0);

        // Async reset mid-cycle with a pending branch
        branch_taken  = 1'b1;
        branch_abs    = 1'b1;
        branch_target = 16'h5555;
        #2;
        RST_N = 1'b0;
        #1;
        check_state("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        check_count("async_rst", 16'h0000);
        @(posedge CLK);
        #3;
        RST_N = 1'b1;
        repeat (2) step();
        check_state("post_rst_idle", 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
